hilo_op_sequencer: RTL and testbench
====================================

Name: hilo_op_sequencer

Overview:
- Sequences the multi-cycle divider and multiplier units for the HI/LO datapath of the multicycle CPU.
- Accepts one mult/div request from the main control FSM, starts the selected unit with a one-cycle start pulse and waits for its done flag.
- Commits the result into the architectural HI/LO registers, or raises a divide-by-zero or timeout exception.
- Asserts a stall for MFHI/MFLO while an operation is in flight.

Parameters:
- TIMEOUT_CYCLES, 48, maximum cycles spent in WAIT before the timeout exception fires (must exceed worst-case unit latency of 34 cycles).
- CNT_W, 6, width of the watchdog counter (2^CNT_W > TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  request from control FSM, sampled only while op_ready=1
- op_is_div  in  1  1=div, 0=mult; captured with op_valid
- op_ready  out  1  1 when in IDLE
- div_start  out  1  one-cycle start pulse to divider (drives its divControl)
- div_stop  in  1  divider done flag
- div_zero  in  1  divider divide-by-zero flag
- div_hi  in  32  divider remainder
- div_lo  in  32  divider quotient
- mult_start  out  1  one-cycle start pulse to multiplier
- mult_done  in  1  multiplier done flag
- mult_hi  in  32  product [63:32]
- mult_lo  in  32  product [31:0]
- hi_out  out  32  architectural HI register
- lo_out  out  32  architectural LO register
- op_done  out  1  one-cycle pulse on successful commit
- exc_div_zero  out  1  one-cycle pulse, divide-by-zero exception
- exc_timeout  out  1  one-cycle pulse, unit failed to finish
- hilo_stall  out  1  1 from request acceptance until commit or exception (inclusive of the commit cycle)

Behaviour:
- Reset (sync, active-high, clk rising edge) values:
  - state=IDLE, op_ready=1, hilo_stall=0.
  - hi_out=lo_out=0.
  - All start and exception pulses 0.
  - Watchdog=0, captured op_is_div=0.
- Reset mid-operation aborts immediately:
  - State returns to IDLE and no commit occurs.
  - Start pulses drop the same edge.
  - A late div_stop/mult_done arriving afterwards in IDLE is ignored.
- IDLE:
  - op_ready=1.
  - On op_valid=1, capture op_is_div, set hilo_stall=1, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - Assert div_start if div, else mult_start; the other start stays 0.
  - Clear the watchdog. Go to WAIT.
  - Done/zero inputs are ignored in this cycle; their values are stale from the previous op.
- WAIT:
  - Watchdog increments each cycle.
  - Div, div_stop=1 and div_zero=1: go to EXC_ZERO. Divide-by-zero takes priority over commit.
  - Div, div_stop=1 and div_zero=0: latch hi_out<=div_hi, lo_out<=div_lo, go to COMMIT.
  - Mult, mult_done=1: latch hi_out<=mult_hi, lo_out<=mult_lo, go to COMMIT.
  - Watchdog==TIMEOUT_CYCLES-1 with no done: go to EXC_TIME. Done in that same cycle wins.
  - Done flags of the non-selected unit are ignored.
- COMMIT (1 cycle):
  - op_done=1, hilo_stall=1. Go to IDLE.
  - New HI/LO values are visible on hi_out/lo_out this cycle.
- EXC_ZERO (1 cycle): exc_div_zero=1, hi_out/lo_out unchanged, go to IDLE.
- EXC_TIME (1 cycle): exc_timeout=1, hi_out/lo_out unchanged, go to IDLE.
- Back-to-back requests:
  - op_valid held high through COMMIT is accepted in the following IDLE cycle.
  - Minimum op-to-op spacing is the unit latency + 3 cycles.
- op_valid while op_ready=0 is dropped. The control FSM must hold it or re-issue.
- Arithmetic: none; pure sequencing. Signed corrections are done inside the units. Full 32-bit results are passed through unchanged.
- Exactly one of op_done/exc_div_zero/exc_timeout pulses per accepted request.

Test Plan:
- Div 7/2: op_valid, op_is_div=1 with real divider -> div_start pulse 1 cycle after accept; lo_out=3, hi_out=1; op_done pulses once; hilo_stall deasserts the cycle after COMMIT.
- Div -7/2: a=0xFFFFFFF9, b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; no exception.
- Div by zero: preload hi/lo=0x11111111/0x22222222, then divide 5/0 -> exc_div_zero pulse; hi/lo retained; op_done stays 0.
- Mult: stub returning mult_done after 32 cycles with 0x00000001/0x80000000 -> hi_out=0x00000001, lo_out=0x80000000; div_start never asserted.
- Timeout: stub divider never asserts div_stop -> exc_timeout exactly TIMEOUT_CYCLES cycles after LAUNCH; a later div_stop is ignored in IDLE.
- Reset mid-op: assert reset 10 cycles into WAIT -> next cycle state IDLE, hi/lo=0, no op_done; a subsequent request completes normally.

Source files
------------

// File: rtl/hilo_op_sequencer.sv
// HI/LO operation sequencer for the multicycle CPU.
// Launches the divider or multiplier with a one-cycle start pulse, waits for
// its done flag under a watchdog, then commits HI/LO or raises an exception.
// All outputs are registered; each transition sets the outputs of the state
// being entered.
module hilo_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 48,
  parameter int unsigned CNT_W          = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  output logic        op_ready,
  output logic        div_start,
  input  logic        div_stop,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mult_start,
  input  logic        mult_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        op_done,
  output logic        exc_div_zero,
  output logic        exc_timeout,
  output logic        hilo_stall
);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StCommit,
    StExcZero,
    StExcTime
  } state_e;

  // Last watchdog value at which a done flag is still accepted.
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] watchdog;
  logic             is_div;

  // Sequencer FSM with registered outputs and HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      watchdog     <= '0;
      is_div       <= 1'b0;
      op_ready     <= 1'b1;
      hilo_stall   <= 1'b0;
      div_start    <= 1'b0;
      mult_start   <= 1'b0;
      op_done      <= 1'b0;
      exc_div_zero <= 1'b0;
      exc_timeout  <= 1'b0;
      hi_out       <= '0;
      lo_out       <= '0;
    end else begin
      // Pulses default low; only the entering transition raises one.
      div_start    <= 1'b0;
      mult_start   <= 1'b0;
      op_done      <= 1'b0;
      exc_div_zero <= 1'b0;
      exc_timeout  <= 1'b0;

      unique case (state)
        StIdle: begin
          if (op_valid) begin
            is_div     <= op_is_div;
            op_ready   <= 1'b0;
            hilo_stall <= 1'b1;
            div_start  <= op_is_div;
            mult_start <= ~op_is_div;
            state      <= StLaunch;
          end
        end

        // Unit flags are stale from the previous op here, so they are ignored.
        StLaunch: begin
          watchdog <= '0;
          state    <= StWait;
        end

        StWait: begin
          watchdog <= watchdog + 1'b1;
          if (is_div && div_stop) begin
            // Divide-by-zero wins over a normal commit.
            if (div_zero) begin
              exc_div_zero <= 1'b1;
              state        <= StExcZero;
            end else begin
              hi_out  <= div_hi;
              lo_out  <= div_lo;
              op_done <= 1'b1;
              state   <= StCommit;
            end
          end else if (!is_div && mult_done) begin
            hi_out  <= mult_hi;
            lo_out  <= mult_lo;
            op_done <= 1'b1;
            state   <= StCommit;
          end else if (watchdog == WdLast) begin
            exc_timeout <= 1'b1;
            state       <= StExcTime;
          end
        end

        StCommit, StExcZero, StExcTime: begin
          op_ready   <= 1'b1;
          hilo_stall <= 1'b0;
          state      <= StIdle;
        end

        default: begin
          op_ready   <= 1'b1;
          hilo_stall <= 1'b0;
          state      <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_op_sequencer.sv
// Self-checking bench for hilo_op_sequencer with behavioural divider and
// multiplier stubs. Stub latency lat: done is visible in the (lat+1)th WAIT
// cycle, i.e. lat+2 cycles after the LAUNCH cycle.
module tb_hilo_op_sequencer;

  localparam int unsigned T = 48;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_is_div, op_ready;
  logic        div_start, mult_start;
  logic        div_stop = 1'b0, div_zero = 1'b0;
  logic [31:0] div_hi = '0, div_lo = '0;
  logic        mult_done = 1'b0;
  logic [31:0] mult_hi = '0, mult_lo = '0;
  logic [31:0] hi_out, lo_out;
  logic        op_done, exc_div_zero, exc_timeout, hilo_stall;

  hilo_op_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_is_div(op_is_div),
    .op_ready(op_ready), .div_start(div_start), .div_stop(div_stop),
    .div_zero(div_zero), .div_hi(div_hi), .div_lo(div_lo),
    .mult_start(mult_start), .mult_done(mult_done), .mult_hi(mult_hi),
    .mult_lo(mult_lo), .hi_out(hi_out), .lo_out(lo_out), .op_done(op_done),
    .exc_div_zero(exc_div_zero), .exc_timeout(exc_timeout), .hilo_stall(hilo_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_div;
    logic [31:0] a, b, mhi, mlo;
    int          lat;
    logic        never;
    int          kind;  // 0 commit, 1 div-by-zero, 2 timeout
    logic [31:0] ehi, elo;
    int          ecyc;  // negedges from LAUNCH sample to result pulse sample
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] hi, lo;
  } exp_t;

  vec_t tbl[10];
  exp_t sb[$];
  int   total = 0, bad = 0;

  // Current stub configuration.
  logic [31:0] cur_a = '0, cur_b = '0, cur_mhi = '0, cur_mlo = '0;
  int          cur_lat = 1;
  logic        cur_never = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divider stub: signed quotient/remainder, one-cycle stop after cur_lat cycles.
  int dcnt = 0;
  logic dbusy = 1'b0;
  always @(posedge clk) begin
    div_stop <= 1'b0;
    if (div_start) begin
      dbusy    <= !cur_never;
      dcnt     <= cur_lat;
      div_zero <= (cur_b == 0);
      if (cur_b != 0) begin
        div_lo <= $signed(cur_a) / $signed(cur_b);
        div_hi <= $signed(cur_a) % $signed(cur_b);
      end
    end else if (dbusy) begin
      if (dcnt <= 1) begin
        div_stop <= 1'b1;
        dbusy    <= 1'b0;
      end else begin
        dcnt <= dcnt - 1;
      end
    end
  end

  // Multiplier stub: returns the configured product after cur_lat cycles.
  int mcnt = 0;
  logic mbusy = 1'b0;
  always @(posedge clk) begin
    mult_done <= 1'b0;
    if (mult_start) begin
      mbusy   <= !cur_never;
      mcnt    <= cur_lat;
      mult_hi <= cur_mhi;
      mult_lo <= cur_mlo;
    end else if (mbusy) begin
      if (mcnt <= 1) begin
        mult_done <= 1'b1;
        mbusy     <= 1'b0;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Scoreboard monitor: every result pulse pops one expectation.
  exp_t mon_e;
  int   mon_kind;
  always @(negedge clk) begin
    if (!reset && (op_done || exc_div_zero || exc_timeout)) begin
      mon_kind = op_done ? 0 : (exc_div_zero ? 1 : 2);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got kind %0d expected none", mon_kind);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_onehot", 64'($countones({op_done, exc_div_zero, exc_timeout})), 64'd1);
        check("result_kind", 64'(mon_kind), 64'(mon_e.kind));
        check("hi_out", {32'd0, hi_out}, {32'd0, mon_e.hi});
        check("lo_out", {32'd0, lo_out}, {32'd0, mon_e.lo});
      end
    end
  end

  task automatic run_op(input int i);
    vec_t v;
    exp_t e;
    int   n;
    v = tbl[i];
    cur_a = v.a; cur_b = v.b; cur_mhi = v.mhi; cur_mlo = v.mlo;
    cur_lat = v.lat; cur_never = v.never;
    n = 0;
    while (!op_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    op_valid  = 1'b1;
    op_is_div = v.is_div;
    @(posedge clk);
    e.kind = v.kind; e.hi = v.ehi; e.lo = v.elo;
    sb.push_back(e);
    @(negedge clk);
    op_valid = 1'b0;
    // LAUNCH cycle: exactly the selected start pulse.
    check($sformatf("v%0d div_start", i), 64'(div_start), 64'(v.is_div));
    check($sformatf("v%0d mult_start", i), 64'(mult_start), 64'(!v.is_div));
    check($sformatf("v%0d launch_stall", i), {62'd0, hilo_stall, op_ready}, 64'b10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (div_start || mult_start) check($sformatf("v%0d extra_start", i), 64'd1, 64'd0);
    end while (!(op_done || exc_div_zero || exc_timeout) && n < 200);
    check($sformatf("v%0d latency", i), 64'(n), 64'(v.ecyc));
    check($sformatf("v%0d stall_at_end", i), 64'(hilo_stall), 64'd1);
    @(negedge clk);
    check($sformatf("v%0d after_end", i),
          {59'd0, op_done, exc_div_zero, exc_timeout, hilo_stall, op_ready}, 64'b00001);
    // Idle gap: late done flags land here and must not touch HI/LO.
    repeat (4) @(negedge clk);
    check($sformatf("v%0d hilo_hold", i), {hi_out, lo_out}, {v.ehi, v.elo});
  endtask

  initial begin
    int n, starts, pulses, first, second;
    //            div   a              b       mhi            mlo            lat nev kind ehi            elo            cyc
    tbl[0] = '{1'b1, 32'd7,         32'd2,  32'd0,         32'd0,         33, 1'b0, 0, 32'd1,         32'd3,         35};
    tbl[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,  32'd0,         32'd0,         34, 1'b0, 0, 32'hFFFFFFFF,  32'hFFFFFFFD,  36};
    tbl[2] = '{1'b0, 32'd0,         32'd0,  32'h11111111,  32'h22222222,  5,  1'b0, 0, 32'h11111111,  32'h22222222,  7};
    tbl[3] = '{1'b1, 32'd5,         32'd0,  32'd0,         32'd0,         10, 1'b0, 1, 32'h11111111,  32'h22222222,  12};
    tbl[4] = '{1'b0, 32'd0,         32'd0,  32'h00000001,  32'h80000000,  32, 1'b0, 0, 32'h00000001,  32'h80000000,  34};
    tbl[5] = '{1'b1, 32'd9,         32'd3,  32'd0,         32'd0,         1,  1'b1, 2, 32'h00000001,  32'h80000000,  T+1};
    tbl[6] = '{1'b0, 32'd0,         32'd0,  32'hDEADBEEF,  32'h12345678,  T-1, 1'b0, 0, 32'hDEADBEEF, 32'h12345678,  T+1};
    tbl[7] = '{1'b1, 32'd100,       32'd7,  32'd0,         32'd0,         T+2, 1'b0, 2, 32'hDEADBEEF, 32'h12345678,  T+1};
    tbl[8] = '{1'b1, 32'd100,       32'd7,  32'd0,         32'd0,         1,  1'b0, 0, 32'd2,         32'd14,        3};
    tbl[9] = '{1'b0, 32'd0,         32'd0,  32'hFFFFFFFF,  32'hFFFFFFFF,  1,  1'b0, 0, 32'hFFFFFFFF,  32'hFFFFFFFF,  3};

    reset = 1'b1; op_valid = 1'b0; op_is_div = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state",
          {op_ready, hilo_stall, div_start, mult_start, op_done, exc_div_zero, exc_timeout},
          7'b1000000);
    check("reset_hilo", {hi_out, lo_out}, 64'd0);

    for (int i = 0; i < 10; i++) run_op(i);

    // Back-to-back: op_valid held through COMMIT is accepted in the next IDLE.
    cur_mhi = 32'hA; cur_mlo = 32'hB; cur_lat = 3; cur_never = 1'b0;
    sb.push_back('{0, 32'hA, 32'hB});
    sb.push_back('{0, 32'hA, 32'hB});
    @(negedge clk);
    op_valid = 1'b1; op_is_div = 1'b0;
    starts = 0; first = 0; second = 0; n = 0;
    while (starts < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (mult_start) begin
        starts++;
        if (starts == 1) first = n; else second = n;
      end
    end
    op_valid = 1'b0;
    check("b2b_starts", 64'(starts), 64'd2);
    check("b2b_spacing", 64'(second - first), 64'(cur_lat + 4));
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);

    // Reset ten cycles into WAIT aborts the op; the late div_stop is ignored.
    cur_a = 32'd7; cur_b = 32'd2; cur_lat = 30; cur_never = 1'b0;
    op_valid = 1'b1; op_is_div = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!div_start && n < 20);
    op_valid = 1'b0;
    check("abort_launch", 64'(div_start), 64'd1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", {op_ready, hilo_stall, div_start, op_done}, 4'b1000);
    check("abort_hilo", {hi_out, lo_out}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (op_done || exc_div_zero || exc_timeout) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);
    check("abort_hilo_hold", {hi_out, lo_out}, 64'd0);
    run_op(0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
